// File: rtl/page_buffer_reader.sv
// page_buffer_reader: reads a contiguous run of bits from a 1024x1 page buffer.
// The buffer has registered read data and an active-low read enable. Bits are
// packed MSB-first into bytes, and each byte is handed downstream over a
// valid/ready handshake. Every output comes straight from a flop.
module page_buffer_reader (
    input  logic        MCLK,
    input  logic        RESET,
    input  logic        START,
    input  logic [9:0]  STARTADDR,
    input  logic [10:0] BITCOUNT,
    output logic        BUSY,
    output logic        DONE,
    output logic [9:0]  RDADDR,
    output logic        nRDCLKEN,
    input  logic        RAMDOUT,
    output logic [7:0]  BYTE_DATA,
    output logic        BYTE_VALID,
    input  logic        BYTE_READY
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DRAIN   = 3'd2,
        S_PRESENT = 3'd3,
        S_FINISH  = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [9:0]  r_addr;        // doubles as RDADDR: always the last address read
    logic [10:0] r_remaining;   // bits still to be read
    logic [2:0]  r_bitpos;      // read index within the current byte
    logic        r_cap_valid;   // a read was issued last cycle, so RAMDOUT is live
    logic [2:0]  r_cap_pos;     // byte position that the live RAMDOUT bit belongs to
    logic [7:0]  r_shift;
    logic [7:0]  r_byte;
    logic        r_busy;
    logic        r_done;
    logic        r_valid;
    logic        r_nrdclken;
    logic [10:0] w_count;
    logic [7:0]  w_shift_next;
    logic        w_busy;
    logic        w_done;
    logic        w_valid;
    logic        w_nrdclken;

    assign w_count = (BITCOUNT > 11'd1024) ? 11'd1024 : BITCOUNT;

    // State register
    always_ff @(posedge MCLK) begin
        if (RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (START) begin
                    w_next_state = (w_count == 11'd0) ? S_FINISH : S_FETCH;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_FETCH: begin
                // The read issued this cycle is the last one for the current byte.
                if ((r_bitpos == 3'd7) || (r_remaining == 11'd1)) begin
                    w_next_state = S_DRAIN;
                end else begin
                    w_next_state = S_FETCH;
                end
            end
            S_DRAIN: w_next_state = S_PRESENT;
            S_PRESENT: begin
                if (BYTE_READY) begin
                    w_next_state = (r_remaining != 11'd0) ? S_FETCH : S_FINISH;
                end else begin
                    w_next_state = S_PRESENT;
                end
            end
            S_FINISH: w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // Output decode from the next state, so the registered outputs line up with the state
    always_comb begin
        w_busy     = 1'b0;
        w_done     = 1'b0;
        w_valid    = 1'b0;
        w_nrdclken = 1'b1;
        case (w_next_state)
            S_FETCH: begin
                w_busy     = 1'b1;
                w_nrdclken = 1'b0;
            end
            S_DRAIN:   w_busy = 1'b1;
            S_PRESENT: begin
                w_busy  = 1'b1;
                w_valid = 1'b1;
            end
            S_FINISH:  w_done = 1'b1;
            default:   w_busy = 1'b0;
        endcase
    end

    // Output registers
    always_ff @(posedge MCLK) begin
        if (RESET) begin
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_valid    <= 1'b0;
            r_nrdclken <= 1'b1;
        end else begin
            r_busy     <= w_busy;
            r_done     <= w_done;
            r_valid    <= w_valid;
            r_nrdclken <= w_nrdclken;
        end
    end

    // Address and bit counters; the address only advances on entry to another read
    always_ff @(posedge MCLK) begin
        if (RESET) begin
            r_addr      <= 10'd0;
            r_remaining <= 11'd0;
            r_bitpos    <= 3'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (START) begin
                        r_addr      <= STARTADDR;
                        r_remaining <= w_count;
                        r_bitpos    <= 3'd0;
                    end
                end
                S_FETCH: begin
                    r_remaining <= r_remaining - 11'd1;
                    r_bitpos    <= r_bitpos + 3'd1;
                    if (w_next_state == S_FETCH) begin
                        r_addr <= r_addr + 10'd1;
                    end
                end
                S_PRESENT: begin
                    if (w_next_state == S_FETCH) begin
                        r_addr   <= r_addr + 10'd1;
                        r_bitpos <= 3'd0;
                    end
                end
                default: r_remaining <= r_remaining;
            endcase
        end
    end

    // Place the live RAMDOUT bit into its byte position, MSB first
    always_comb begin
        w_shift_next = r_shift;
        if (r_cap_valid) begin
            w_shift_next[3'd7 - r_cap_pos] = RAMDOUT;
        end else begin
            w_shift_next = r_shift;
        end
    end

    // Capture pipeline; byte assembly is cleared at the start of each byte
    always_ff @(posedge MCLK) begin
        if (RESET) begin
            r_cap_valid <= 1'b0;
            r_cap_pos   <= 3'd0;
            r_shift     <= 8'h00;
            r_byte      <= 8'h00;
        end else begin
            r_cap_valid <= (r_state == S_FETCH);
            r_cap_pos   <= r_bitpos;
            if ((r_state != S_FETCH) && (w_next_state == S_FETCH)) begin
                r_shift <= 8'h00;
            end else begin
                r_shift <= w_shift_next;
            end
            if (r_state == S_DRAIN) begin
                r_byte <= w_shift_next;
            end
        end
    end

    assign BUSY       = r_busy;
    assign DONE       = r_done;
    assign BYTE_VALID = r_valid;
    assign nRDCLKEN   = r_nrdclken;
    assign RDADDR     = r_addr;
    assign BYTE_DATA  = r_byte;

endmodule

// File: tb/tb_page_buffer_reader.sv
// Testbench for page_buffer_reader: a behavioural page buffer, a scoreboard
// fed from the command side, and a monitor that checks every read and every byte.
module tb_page_buffer_reader;

    logic        MCLK = 1'b0;
    logic        RESET;
    logic        START;
    logic [9:0]  STARTADDR;
    logic [10:0] BITCOUNT;
    logic        BUSY;
    logic        DONE;
    logic [9:0]  RDADDR;
    logic        nRDCLKEN;
    logic        RAMDOUT = 1'b0;
    logic [7:0]  BYTE_DATA;
    logic        BYTE_VALID;
    logic        BYTE_READY = 1'b0;

    page_buffer_reader dut (
        .MCLK(MCLK), .RESET(RESET), .START(START), .STARTADDR(STARTADDR),
        .BITCOUNT(BITCOUNT), .BUSY(BUSY), .DONE(DONE), .RDADDR(RDADDR),
        .nRDCLKEN(nRDCLKEN), .RAMDOUT(RAMDOUT), .BYTE_DATA(BYTE_DATA),
        .BYTE_VALID(BYTE_VALID), .BYTE_READY(BYTE_READY)
    );

    always #5 MCLK = ~MCLK;

    logic       mem [0:1023];
    int         n_pass = 0;
    int         n_checks = 0;
    logic [7:0] exp_bytes[$];
    int         exp_addrs[$];
    int         n_bytes_seen = 0;
    int         n_reads_seen = 0;
    logic [7:0] last_byte = 8'h00;
    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic       rdy_rand = 1'b0;
    logic       rdy_fixed = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Page buffer: registered read data
    always @(posedge MCLK) begin
        if (nRDCLKEN === 1'b0) RAMDOUT <= mem[RDADDR];
    end

    // Consumer ready: random or fixed
    always @(posedge MCLK) begin
        #1;
        if (rdy_rand) BYTE_READY = ($urandom_range(0, 2) == 0);
        else          BYTE_READY = rdy_fixed;
    end

    // Monitor: reads, bytes, done, handshake stability
    always @(negedge MCLK) begin
        if (RESET !== 1'b0) begin
            prev_valid = 1'b0;
        end else begin
            if (prev_valid && !prev_ready) begin
                check("valid_held", BYTE_VALID, 1);
                check("data_stable", BYTE_DATA, prev_data);
            end
            if (nRDCLKEN == 1'b0) begin
                n_reads_seen++;
                check("read_expected", exp_addrs.size() > 0, 1);
                if (exp_addrs.size() > 0) check("rdaddr", RDADDR, exp_addrs.pop_front());
            end
            if (BYTE_VALID) check("no_read_in_present", nRDCLKEN, 1);
            if (BYTE_VALID && BYTE_READY) begin
                n_bytes_seen++;
                last_byte = BYTE_DATA;
                check("byte_expected", exp_bytes.size() > 0, 1);
                if (exp_bytes.size() > 0) check("byte_data", BYTE_DATA, exp_bytes.pop_front());
            end
            if (DONE) begin
                check("done_bytes_left", exp_bytes.size(), 0);
                check("done_reads_left", exp_addrs.size(), 0);
                check("busy_in_done", BUSY, 0);
            end
            prev_valid = BYTE_VALID;
            prev_ready = BYTE_READY;
            prev_data  = BYTE_DATA;
        end
    end

    // Reference model: list of addresses read and bytes produced, then pulse START
    task automatic start_cmd(input int addr, input int cnt);
        int n;
        logic [7:0] b;
        n = (cnt > 1024) ? 1024 : cnt;
        for (int i = 0; i < n; i++) exp_addrs.push_back((addr + i) % 1024);
        for (int k = 0; k < n; k += 8) begin
            b = 8'h00;
            for (int j = 0; (j < 8) && (k + j < n); j++) b[7 - j] = mem[(addr + k + j) % 1024];
            exp_bytes.push_back(b);
        end
        @(posedge MCLK); #1;
        START = 1'b1;
        STARTADDR = addr[9:0];
        BITCOUNT = cnt[10:0];
        @(posedge MCLK); #1;
        START = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        logic got;
        got = 1'b0;
        for (int c = 0; (c < limit) && !got; c++) begin
            @(negedge MCLK);
            if (DONE) got = 1'b1;
        end
        check("done_seen", got, 1);
        @(posedge MCLK); #1;
    endtask

    task automatic reset_checks();
        check("rst_busy", BUSY, 0);
        check("rst_done", DONE, 0);
        check("rst_valid", BYTE_VALID, 0);
        check("rst_data", BYTE_DATA, 8'h00);
        check("rst_nrdclken", nRDCLKEN, 1);
        check("rst_rdaddr", RDADDR, 10'd0);
    endtask

    task automatic do_reset();
        @(posedge MCLK); #1;
        RESET = 1'b1;
        START = 1'b0;
        @(posedge MCLK); #1;
        RESET = 1'b0;
        exp_addrs.delete();
        exp_bytes.delete();
        @(negedge MCLK);
        reset_checks();
    endtask

    task automatic wait_valid(input int limit);
        logic got;
        got = 1'b0;
        for (int c = 0; (c < limit) && !got; c++) begin
            @(negedge MCLK);
            if (BYTE_VALID) got = 1'b1;
        end
        check("valid_seen", got, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    logic       r_nrd [0:15];
    logic       r_busy [0:15];
    logic       r_valid [0:15];
    logic       r_done [0:15];
    logic [7:0] r_data [0:15];
    int         nb0;
    int         nr0;

    initial begin
        RESET = 1'b1; START = 1'b0; STARTADDR = 10'd0; BITCOUNT = 11'd0;
        for (int i = 0; i < 1024; i++) mem[i] = 1'b0;
        repeat (2) @(posedge MCLK);
        #1 RESET = 1'b0;
        @(negedge MCLK);
        reset_checks();

        // 0xA5 at bits 0..7, exact cycle timing
        {mem[0], mem[1], mem[2], mem[3], mem[4], mem[5], mem[6], mem[7]} = 8'hA5;
        rdy_fixed = 1'b1;
        start_cmd(0, 8);
        for (int c = 1; c <= 12; c++) begin
            @(negedge MCLK);
            r_nrd[c] = nRDCLKEN; r_busy[c] = BUSY; r_valid[c] = BYTE_VALID;
            r_done[c] = DONE; r_data[c] = BYTE_DATA;
        end
        check("t_first_read_c1", r_nrd[1], 0);
        check("t_busy_c1", r_busy[1], 1);
        check("t_last_read_c8", r_nrd[8], 0);
        check("t_drain_c9", r_nrd[9], 1);
        check("t_valid_c9", r_valid[9], 0);
        check("t_valid_c10", r_valid[10], 1);
        check("t_data_c10", r_data[10], 8'hA5);
        check("t_done_c11", r_done[11], 1);
        check("t_busy_c11", r_busy[11], 0);
        check("t_done_c12", r_done[12], 0);
        @(posedge MCLK); #1;

        // Address wrap 1020..3
        {mem[1020], mem[1021], mem[1022], mem[1023]} = 4'b1011;
        {mem[0], mem[1], mem[2], mem[3]} = 4'b0011;
        start_cmd(1020, 8);
        wait_done(50);
        check("wrap_byte", last_byte, 8'hB3);

        // Partial bytes
        {mem[0], mem[1], mem[2]} = 3'b111;
        mem[3] = 1'b0;
        nb0 = n_bytes_seen;
        start_cmd(0, 3);
        wait_done(50);
        check("partial3_byte", last_byte, 8'hE0);
        check("partial3_count", n_bytes_seen - nb0, 1);
        nb0 = n_bytes_seen;
        start_cmd(0, 12);
        wait_done(80);
        check("partial12_count", n_bytes_seen - nb0, 2);

        for (int i = 0; i < 1024; i++) mem[i] = 1'($urandom_range(0, 1));

        // Backpressure: 20 stalled cycles, then second byte 10 cycles after handshake
        rdy_fixed = 1'b0;
        start_cmd(100, 16);
        wait_valid(30);
        for (int c = 0; c < 20; c++) begin
            @(negedge MCLK);
            check("bp_stall_nrd", nRDCLKEN, 1);
            check("bp_stall_valid", BYTE_VALID, 1);
        end
        rdy_fixed = 1'b1;
        @(posedge MCLK);
        @(posedge MCLK);
        for (int r = 1; r <= 10; r++) begin
            @(negedge MCLK);
            r_valid[r] = BYTE_VALID;
        end
        check("bp_valid_rel9", r_valid[9], 0);
        check("bp_valid_rel10", r_valid[10], 1);
        wait_done(30);

        // Zero count
        start_cmd(5, 0);
        @(negedge MCLK);
        check("zero_done_c1", DONE, 1);
        check("zero_busy_c1", BUSY, 0);
        check("zero_nrd_c1", nRDCLKEN, 1);
        check("zero_valid_c1", BYTE_VALID, 0);
        @(posedge MCLK); #1;

        // START while busy is ignored
        rdy_rand = 1'b1;
        start_cmd(500, 24);
        repeat (5) @(posedge MCLK);
        #1;
        START = 1'b1; STARTADDR = 10'd7; BITCOUNT = 11'd5;
        @(posedge MCLK); #1;
        START = 1'b0;
        wait_done(300);

        // Clamp to 1024
        nb0 = n_bytes_seen;
        nr0 = n_reads_seen;
        start_cmd($urandom_range(0, 1023), 2000);
        wait_done(5000);
        check("clamp_bytes", n_bytes_seen - nb0, 128);
        check("clamp_reads", n_reads_seen - nr0, 1024);

        // Random transfers
        for (int t = 0; t < 15; t++) begin
            start_cmd($urandom_range(0, 1023), $urandom_range(1, 40));
            wait_done(600);
        end

        // Reset mid-FETCH, then a clean transfer
        rdy_rand = 1'b0;
        rdy_fixed = 1'b1;
        start_cmd(200, 16);
        repeat (3) @(posedge MCLK);
        do_reset();
        start_cmd(200, 16);
        wait_done(100);

        // Reset while presenting, then a clean transfer
        rdy_fixed = 1'b0;
        start_cmd(300, 8);
        wait_valid(30);
        do_reset();
        rdy_fixed = 1'b1;
        start_cmd(300, 8);
        wait_done(50);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/page_buffer_reader.md
# page_buffer_reader

Read-side controller for a 1024×1 bit page buffer (registered read data, active-low read clock-enable). It streams a contiguous run of bits from the buffer on command, packs them MSB-first into bytes, and hands each byte to a downstream consumer (the host readback path) over a valid/ready handshake. It is the reader for the buffer the bubble-emulation datapath writes into.

## Interface
Parameters: none; buffer depth fixed at 1024 bits (10-bit address).

- MCLK  in  1  system clock; all logic on rising edge
- RESET  in  1  reset, synchronous, active-high
- START  in  1  one-cycle command pulse; sampled only when BUSY=0
- STARTADDR  in  10  first bit address, sampled with START
- BITCOUNT  in  11  bits to read, sampled with START; 0..1024, values >1024 clamp to 1024
- BUSY  out  1  high from cycle after accepted START until DONE cycle
- DONE  out  1  one-cycle pulse, transfer complete
- RDADDR  out  10  buffer read address
- nRDCLKEN  out  1  buffer read enable, active-low
- RAMDOUT  in  1  buffer read data, valid the cycle after the read is issued
- BYTE_DATA  out  8  packed byte; first bit read lands in bit 7
- BYTE_VALID  out  1  BYTE_DATA valid
- BYTE_READY  in  1  consumer accepts byte when BYTE_VALID & BYTE_READY on a rising edge

## Operation
- States: IDLE, FETCH, DRAIN, PRESENT, FINISH.
- IDLE: BUSY=0, nRDCLKEN=1. START=1 latches STARTADDR into address counter, clamped BITCOUNT into remaining-bit counter (11 bits). BITCOUNT=0 -> FINISH directly; else -> FETCH.
- FETCH: each cycle drives nRDCLKEN=0, RDADDR=address counter; address increments mod 1024 (1023 -> 0), remaining decrements. Issues min(8, remaining) reads back-to-back, then -> DRAIN.
- Capture: RAMDOUT sampled the cycle after each issued read into shift position 7,6,...,0 in order. Unused positions of a short final byte are 0.
- DRAIN: nRDCLKEN=1; captures last bit; loads BYTE_DATA; -> PRESENT.
- PRESENT: BYTE_VALID=1, BYTE_DATA stable until handshake. On handshake: remaining>0 -> FETCH, else -> FINISH. No reads issued while in PRESENT.
- FINISH: DONE=1 for one cycle, BUSY=0 in that cycle -> IDLE.
- START while BUSY=1: ignored, no effect on in-flight transfer.
- RESET (any state, any cycle): -> IDLE; BYTE_VALID=0, BYTE_DATA=0, DONE=0, BUSY=0, nRDCLKEN=1, RDADDR=0, counters=0. Pending byte discarded.

## Timing
- Reset values: BUSY 0, DONE 0, BYTE_VALID 0, BYTE_DATA 8'h00, nRDCLKEN 1, RDADDR 0.
- START in cycle 0 -> BUSY=1 and first read (nRDCLKEN=0) in cycle 1.
- Full byte: reads cycles 1..8, DRAIN cycle 9, BYTE_VALID=1 from cycle 10.
- With BYTE_READY held high: one byte per 10 cycles (8 fetch, 1 drain, 1 present); next FETCH begins cycle after handshake.
- Short final byte of k bits: k fetch cycles, 1 drain, then PRESENT.
- DONE asserted cycle after final handshake; BITCOUNT=0 -> DONE in cycle 1, no BYTE_VALID.
- BYTE_VALID never deasserts without handshake except on RESET.
- RDADDR is don't-care when nRDCLKEN=1 but holds last value (no glitch toggling).

## Test plan
- Buffer preloaded 0xA5 at bits 0..7, START addr=0 count=8, BYTE_READY=1 -> reads at addrs 0..7 in cycles 1..8, BYTE_VALID cycle 10 with BYTE_DATA=8'hA5, DONE cycle 11.
- Wrap: bits 1020..1023 = 1,0,1,1 and 0..3 = 0,0,1,1, START addr=1020 count=8 -> RDADDR sequence 1020,1021,1022,1023,0,1,2,3; BYTE_DATA=8'hB3.
- Partial byte: bits 0..2 = 1,1,1, count=3 -> one byte 8'hE0, DONE after its handshake; count=12 -> two bytes, second with 4 valid MSBs.
- Backpressure: count=16, BYTE_READY low 20 cycles after first BYTE_VALID -> BYTE_DATA stable, nRDCLKEN=1 throughout stall; second byte follows 10 cycles after handshake.
- Edge counts: count=0 -> DONE cycle 1, no reads; count=2000 -> clamped, exactly 128 bytes, 1024 reads; START during BUSY -> ignored.
- RESET asserted mid-FETCH and during PRESENT -> next cycle all outputs at reset values; fresh START then completes normally.
